// File: rtl/mcu51_pkg.sv
// Shared definitions for the MCU51 interrupt controller: SFR map, source indices and
// priority-level encodings.
package mcu51_pkg;

    localparam logic [7:0] TCON_ADDR = 8'h88;
    localparam logic [7:0] IE_ADDR   = 8'hA8;
    localparam logic [7:0] IP_ADDR   = 8'hB8;

    // Implemented bits only; the rest read back as zero.
    localparam logic [7:0] IE_MASK = 8'h9F;
    localparam logic [7:0] IP_MASK = 8'h1F;

    localparam int NSRC = 5;

    // Index order doubles as the fixed tie-break order (lowest index wins).
    typedef enum logic [2:0] {
        SRC_IE0 = 3'd0,
        SRC_TF0 = 3'd1,
        SRC_IE1 = 3'd2,
        SRC_TF1 = 3'd3,
        SRC_SER = 3'd4
    } src_e;

    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_LOW  = 2'd1;
    localparam logic [1:0] LVL_HIGH = 2'd2;

    function automatic logic [1:0] cur_level(input logic [1:0] in_service);
        if (in_service[1]) return LVL_HIGH;
        if (in_service[0]) return LVL_LOW;
        return LVL_NONE;
    endfunction

endpackage

// File: rtl/mcu51_int_ctrl_if.sv
// SFR bus and CPU interrupt handshake between the MCU51 core and the interrupt controller.
interface mcu51_int_ctrl_if;

    logic        sfr_wr;
    logic [7:0]  sfr_addr;
    logic [7:0]  sfr_wdata;
    logic [7:0]  sfr_rdata;
    logic        sfr_hit;
    logic        irq_req;
    logic [15:0] irq_vec;
    logic        irq_ack;
    logic        reti;

    modport master (
        output sfr_wr, sfr_addr, sfr_wdata, irq_ack, reti,
        input  sfr_rdata, sfr_hit, irq_req, irq_vec
    );

    modport slave (
        input  sfr_wr, sfr_addr, sfr_wdata, irq_ack, reti,
        output sfr_rdata, sfr_hit, irq_req, irq_vec
    );

endinterface

// File: rtl/mcu51_int_edge.sv
// Pin synchroniser plus falling-edge detector for an active-low external interrupt pin.
module mcu51_int_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_n,
    output logic level,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    // Flops reset high so an idle pin does not look like a falling edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '1;
            prev_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin_n};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign fall  = prev_reg & ~level;

endmodule

// File: rtl/mcu51_int_ctrl.sv
// MCU51 interrupt arbiter: TCON/IE/IP SFRs, two-level priority with nesting, RETI unwinding
// and a registered request/vector towards the CPU.
module mcu51_int_ctrl
    import mcu51_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] VEC_BASE    = 16'h0003,
    parameter logic [15:0] VEC_STRIDE  = 16'h0008
) (
    input  logic CLK,
    input  logic reset,
    input  logic int0_n,
    input  logic int1_n,
    input  logic tf0,
    input  logic tf1,
    input  logic ri,
    input  logic ti,
    output logic tf0_clr,
    output logic tf1_clr,
    mcu51_int_ctrl_if.slave bus
);

    logic [7:0]      ie_reg;
    logic [7:0]      ip_reg;
    logic [1:0]      it_reg;
    logic [1:0]      iex_reg;
    logic [1:0]      iex_next;
    logic [1:0]      ext_pin_n;
    logic [1:0]      ext_level;
    logic [1:0]      ext_fall;
    logic [1:0]      in_service_reg;
    logic [1:0]      in_service_next;
    logic            irq_req_reg;
    logic [15:0]     irq_vec_reg;
    src_e            win_idx_reg;
    src_e            win_idx;
    logic            win_hi_reg;
    logic            win_hi;
    logic            tf0_clr_reg;
    logic            tf1_clr_reg;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] elig;
    logic [1:0]      cur_lvl;
    logic            any_elig;
    logic            ack_ok;
    logic            tcon_wr;
    logic [7:0]      rdata;

    assign ext_pin_n = {int1_n, int0_n};
    assign ack_ok    = bus.irq_ack & irq_req_reg;
    assign tcon_wr   = bus.sfr_wr & (bus.sfr_addr == TCON_ADDR);

    genvar gi;

    // External sources: TCON bit 2*gi is ITx, bit 2*gi+1 is IEx.
    for (gi = 0; gi < 2; gi++) begin : g_ext
        localparam src_e EXT_SRC = (gi == 0) ? SRC_IE0 : SRC_IE1;

        mcu51_int_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_edge (
            .clk   (CLK),
            .rst_n (reset),
            .pin_n (ext_pin_n[gi]),
            .level (ext_level[gi]),
            .fall  (ext_fall[gi])
        );

        // Level mode tracks the pin; edge mode: hardware set beats ack-clear beats software.
        assign iex_next[gi] = !it_reg[gi]                           ? ~ext_level[gi] :
                              ext_fall[gi]                          ? 1'b1 :
                              (ack_ok && win_idx_reg == EXT_SRC)    ? 1'b0 :
                              tcon_wr                               ? bus.sfr_wdata[2*gi+1] :
                                                                      iex_reg[gi];
    end

    assign pend    = {ri | ti, tf1, iex_reg[1], tf0, iex_reg[0]};
    assign cur_lvl = cur_level(in_service_reg);

    for (gi = 0; gi < NSRC; gi++) begin : g_elig
        logic [1:0] src_lvl;
        assign src_lvl  = ip_reg[gi] ? LVL_HIGH : LVL_LOW;
        assign elig[gi] = ie_reg[7] & ie_reg[gi] & pend[gi] & (src_lvl > cur_lvl);
    end

    assign any_elig = |elig;

    // High-priority group wins if any member is eligible; within a group the lowest index wins.
    always_comb begin
        win_hi  = |(elig & ip_reg[NSRC-1:0]);
        win_idx = SRC_IE0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i] && (ip_reg[i] == win_hi)) win_idx = src_e'(3'(i));
        end
    end

    // RETI unwinds first so a same-cycle ack lands on the already-popped stack.
    always_comb begin
        in_service_next = in_service_reg;
        if (bus.reti) begin
            if (in_service_next[1]) in_service_next[1] = 1'b0;
            else                    in_service_next[0] = 1'b0;
        end
        if (ack_ok) begin
            if (win_hi_reg) in_service_next[1] = 1'b1;
            else            in_service_next[0] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ie_reg         <= '0;
            ip_reg         <= '0;
            it_reg         <= '0;
            iex_reg        <= '0;
            in_service_reg <= '0;
            irq_req_reg    <= 1'b0;
            irq_vec_reg    <= VEC_BASE;
            win_idx_reg    <= SRC_IE0;
            win_hi_reg     <= 1'b0;
            tf0_clr_reg    <= 1'b0;
            tf1_clr_reg    <= 1'b0;
        end else begin
            if (bus.sfr_wr) begin
                case (bus.sfr_addr)
                    IE_ADDR:   ie_reg <= bus.sfr_wdata & IE_MASK;
                    IP_ADDR:   ip_reg <= bus.sfr_wdata & IP_MASK;
                    TCON_ADDR: it_reg <= {bus.sfr_wdata[2], bus.sfr_wdata[0]};
                    default:   ;
                endcase
            end
            iex_reg        <= iex_next;
            in_service_reg <= in_service_next;
            irq_req_reg    <= any_elig & ~ack_ok;
            if (any_elig) begin
                irq_vec_reg <= VEC_BASE + VEC_STRIDE * 16'(win_idx);
                win_idx_reg <= win_idx;
                win_hi_reg  <= win_hi;
            end
            tf0_clr_reg <= ack_ok & (win_idx_reg == SRC_TF0);
            tf1_clr_reg <= ack_ok & (win_idx_reg == SRC_TF1);
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.sfr_addr)
            TCON_ADDR: rdata = {4'b0000, iex_reg[1], it_reg[1], iex_reg[0], it_reg[0]};
            IE_ADDR:   rdata = ie_reg;
            IP_ADDR:   rdata = ip_reg;
            default:   rdata = '0;
        endcase
    end

    assign bus.sfr_rdata = rdata;
    assign bus.sfr_hit   = (bus.sfr_addr == TCON_ADDR) | (bus.sfr_addr == IE_ADDR) |
                           (bus.sfr_addr == IP_ADDR);
    assign bus.irq_req   = irq_req_reg;
    assign bus.irq_vec   = irq_vec_reg;
    assign tf0_clr       = tf0_clr_reg;
    assign tf1_clr       = tf1_clr_reg;

endmodule

// File: tb/tb_mcu51_int_ctrl.sv
// Directed bench for mcu51_int_ctrl with a per-cycle behavioural reference model.
module tb_mcu51_int_ctrl;

    localparam int S = 2;
    localparam logic [7:0] A_TCON = 8'h88;
    localparam logic [7:0] A_IE   = 8'hA8;
    localparam logic [7:0] A_IP   = 8'hB8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic int0_n = 1'b1, int1_n = 1'b1;
    logic tf0 = 1'b0, tf1 = 1'b0, ri = 1'b0, ti = 1'b0;
    logic tf0_clr, tf1_clr;
    bit   started = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mcu51_int_ctrl_if bus ();

    mcu51_int_ctrl #(
        .SYNC_STAGES (S),
        .VEC_BASE    (16'h0003),
        .VEC_STRIDE  (16'h0008)
    ) dut (
        .CLK     (clk),
        .reset   (reset),
        .int0_n  (int0_n),
        .int1_n  (int1_n),
        .tf0     (tf0),
        .tf1     (tf1),
        .ri      (ri),
        .ti      (ti),
        .tf0_clr (tf0_clr),
        .tf1_clr (tf1_clr),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: pending flags, a stack of active priority levels, and pin histories.
    logic [7:0]  m_ie, m_ip;
    bit          m_it0, m_it1, m_ie0, m_ie1;
    bit          m_req, m_tf0c, m_tf1c;
    logic [15:0] m_vec;
    int          m_win, m_win_lvl;
    int          stack[$];
    bit          h0[$], h1[$];
    int          m_cur, m_best, m_score, m_bscore;
    bit          m_ack, fall0, fall1, n_ie0, n_ie1, tcon_w;
    logic [4:0]  m_pend;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ie = 8'h00; m_ip = 8'h00;
            m_it0 = 0; m_it1 = 0; m_ie0 = 0; m_ie1 = 0;
            m_req = 0; m_tf0c = 0; m_tf1c = 0;
            m_vec = 16'h0003; m_win = 0; m_win_lvl = 1;
            stack.delete(); h0.delete(); h1.delete();
            for (int k = 0; k <= S; k++) begin h0.push_back(1'b1); h1.push_back(1'b1); end
        end else begin
            m_cur  = (stack.size() == 0) ? 0 : stack[stack.size() - 1];
            m_pend = {ri | ti, tf1, m_ie1, tf0, m_ie0};
            m_best = -1; m_bscore = -1;
            for (int i = 0; i < 5; i++) begin
                if (m_ie[7] && m_ie[i] && m_pend[i] && ((m_ip[i] ? 2 : 1) > m_cur)) begin
                    m_score = (m_ip[i] ? 10 : 0) + (5 - i);
                    if (m_score > m_bscore) begin m_bscore = m_score; m_best = i; end
                end
            end
            m_ack  = bus.irq_ack && m_req;
            m_tf0c = m_ack && (m_win == 1);
            m_tf1c = m_ack && (m_win == 3);
            if (bus.reti && stack.size() > 0) void'(stack.pop_back());
            if (m_ack) stack.push_back(m_win_lvl);
            tcon_w = bus.sfr_wr && (bus.sfr_addr == A_TCON);
            fall0 = h0[S] && !h0[S-1];
            fall1 = h1[S] && !h1[S-1];
            if (!m_it0) n_ie0 = !h0[S-1];
            else begin
                n_ie0 = m_ie0;
                if (tcon_w) n_ie0 = bus.sfr_wdata[1];
                if (m_ack && m_win == 0) n_ie0 = 0;
                if (fall0) n_ie0 = 1;
            end
            if (!m_it1) n_ie1 = !h1[S-1];
            else begin
                n_ie1 = m_ie1;
                if (tcon_w) n_ie1 = bus.sfr_wdata[3];
                if (m_ack && m_win == 2) n_ie1 = 0;
                if (fall1) n_ie1 = 1;
            end
            m_ie0 = n_ie0; m_ie1 = n_ie1;
            m_req = (m_best >= 0) && !m_ack;
            if (m_best >= 0) begin
                m_vec     = 16'h0003 + 16'(m_best * 8);
                m_win     = m_best;
                m_win_lvl = m_ip[m_best] ? 2 : 1;
            end
            if (bus.sfr_wr) begin
                if (bus.sfr_addr == A_IE) m_ie = bus.sfr_wdata & 8'h9F;
                if (bus.sfr_addr == A_IP) m_ip = bus.sfr_wdata & 8'h1F;
                if (tcon_w) begin m_it0 = bus.sfr_wdata[0]; m_it1 = bus.sfr_wdata[2]; end
            end
            h0.push_front(int0_n); void'(h0.pop_back());
            h1.push_front(int1_n); void'(h1.pop_back());
        end
    end

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        if (a == A_TCON) return {4'b0000, m_ie1, m_it1, m_ie0, m_it0};
        if (a == A_IE)   return m_ie;
        if (a == A_IP)   return m_ip;
        return 8'h00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("cyc_req", {31'd0, bus.irq_req}, {31'd0, m_req});
            if (m_req) chk("cyc_vec", {16'd0, bus.irq_vec}, {16'd0, m_vec});
            chk("cyc_tf0_clr", {31'd0, tf0_clr}, {31'd0, m_tf0c});
            chk("cyc_tf1_clr", {31'd0, tf1_clr}, {31'd0, m_tf1c});
            chk("cyc_rdata", {24'd0, bus.sfr_rdata}, {24'd0, model_rd(bus.sfr_addr)});
            chk("cyc_hit", {31'd0, bus.sfr_hit},
                {31'd0, (bus.sfr_addr == A_TCON) || (bus.sfr_addr == A_IE) || (bus.sfr_addr == A_IP)});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
        bus.sfr_wr = 1'b1; bus.sfr_addr = a; bus.sfr_wdata = d;
        tick(1);
        bus.sfr_wr = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [7:0] exp);
        bus.sfr_addr = a;
        #1;
        chk(nm, {24'd0, bus.sfr_rdata}, {24'd0, exp});
    endtask

    task automatic wait_req(input string nm, input int exp_lat);
        int n = 0;
        while (!bus.irq_req && n < 40) begin tick(1); n++; end
        chk(nm, n, exp_lat);
    endtask

    task automatic do_ack();
        bus.irq_ack = 1'b1; tick(1); bus.irq_ack = 1'b0;
    endtask

    task automatic do_reti();
        bus.reti = 1'b1; tick(1); bus.reti = 1'b0;
    endtask

    initial begin
        bus.sfr_wr = 1'b0; bus.sfr_addr = 8'h00; bus.sfr_wdata = 8'h00;
        bus.irq_ack = 1'b0; bus.reti = 1'b0;
        #1 reset = 1'b0;
        started = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        chk("rst_req", {31'd0, bus.irq_req}, 32'd0);
        chk("rst_vec", {16'd0, bus.irq_vec}, 32'h0003);
        rd_chk("rst_ie", A_IE, 8'h00);
        rd_chk("rst_tcon", A_TCON, 8'h00);

        // 1: edge-triggered INT0
        sfr_write(A_TCON, 8'h01);
        sfr_write(A_IE, 8'h81);
        rd_chk("t1_ie_rd", A_IE, 8'h81);
        int0_n = 1'b0;
        wait_req("t1_latency", S + 2);
        chk("t1_vec", {16'd0, bus.irq_vec}, 32'h0003);
        rd_chk("t1_tcon_pend", A_TCON, 8'h03);
        do_ack();
        chk("t1_req_after_ack", {31'd0, bus.irq_req}, 32'd0);
        rd_chk("t1_tcon_clr", A_TCON, 8'h01);
        int0_n = 1'b1;
        tick(3);
        do_reti();
        tick(2);

        // 2: TF1 high priority beats TF0 low
        sfr_write(A_IE, 8'h8A);
        sfr_write(A_IP, 8'h08);
        tf0 = 1'b1; tf1 = 1'b1;
        wait_req("t2_latency", 1);
        chk("t2_vec", {16'd0, bus.irq_vec}, 32'h001B);
        do_ack();
        chk("t2_tf1_clr", {31'd0, tf1_clr}, 32'd1);
        chk("t2_tf0_clr", {31'd0, tf0_clr}, 32'd0);
        tf1 = 1'b0;
        tick(3);
        chk("t2_tf0_blocked", {31'd0, bus.irq_req}, 32'd0);

        // 3: nesting and unwinding
        do_reti();
        wait_req("t3_tf0_latency", 1);
        chk("t3_tf0_vec", {16'd0, bus.irq_vec}, 32'h000B);
        do_ack();
        chk("t3_tf0_clr", {31'd0, tf0_clr}, 32'd1);
        tf0 = 1'b0;
        tick(1);
        tf1 = 1'b1;
        wait_req("t3_preempt_latency", 1);
        chk("t3_preempt_vec", {16'd0, bus.irq_vec}, 32'h001B);
        do_ack();
        tf1 = 1'b0;
        sfr_write(A_IE, 8'h9A);
        ri = 1'b1;
        tick(3);
        chk("t3_ser_blocked2", {31'd0, bus.irq_req}, 32'd0);
        do_reti();
        tick(3);
        chk("t3_ser_blocked1", {31'd0, bus.irq_req}, 32'd0);
        do_reti();
        wait_req("t3_ser_latency", 1);
        chk("t3_ser_vec", {16'd0, bus.irq_vec}, 32'h0023);
        do_ack();
        ri = 1'b0;
        tick(1);
        do_reti();
        tick(2);

        // 4: level-triggered INT1
        sfr_write(A_TCON, 8'h00);
        sfr_write(A_IP, 8'h00);
        sfr_write(A_IE, 8'h84);
        int1_n = 1'b0;
        wait_req("t4_latency", S + 2);
        chk("t4_vec", {16'd0, bus.irq_vec}, 32'h0013);
        do_ack();
        rd_chk("t4_ie1_kept", A_TCON, 8'h08);
        int1_n = 1'b1;
        tick(4);
        rd_chk("t4_ie1_follow", A_TCON, 8'h00);
        do_reti();
        tick(2);
        chk("t4_idle", {31'd0, bus.irq_req}, 32'd0);

        // 5: EA toggled while a request is pending
        sfr_write(A_TCON, 8'h01);
        sfr_write(A_IE, 8'h81);
        int0_n = 1'b0;
        wait_req("t5_latency", S + 2);
        sfr_write(A_IE, 8'h01);
        tick(1);
        chk("t5_ea_off", {31'd0, bus.irq_req}, 32'd0);
        sfr_write(A_IE, 8'h81);
        tick(1);
        chk("t5_ea_on", {31'd0, bus.irq_req}, 32'd1);
        chk("t5_vec", {16'd0, bus.irq_vec}, 32'h0003);
        do_ack();
        int0_n = 1'b1;
        do_reti();
        tick(2);

        // 6: reset during a serial service routine
        sfr_write(A_IE, 8'h90);
        sfr_write(A_IP, 8'h08);
        ri = 1'b1;
        wait_req("t6_latency", 1);
        chk("t6_vec", {16'd0, bus.irq_vec}, 32'h0023);
        do_ack();
        tick(1);
        reset = 1'b0;
        #1;
        chk("t6_rst_req", {31'd0, bus.irq_req}, 32'd0);
        chk("t6_rst_vec", {16'd0, bus.irq_vec}, 32'h0003);
        chk("t6_rst_tf_clr", {30'd0, tf1_clr, tf0_clr}, 32'd0);
        rd_chk("t6_rst_ie", A_IE, 8'h00);
        tick(1);
        rd_chk("t6_rst_ip", A_IP, 8'h00);
        rd_chk("t6_rst_tcon", A_TCON, 8'h00);
        ri = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);
        chk("t6_post_idle", {31'd0, bus.irq_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
